gamma_sequencer: RTL and testbench
==================================

GAMMA_SEQUENCER -- requirements
Module: gamma_sequencer

Interface
REQ-001 SHALL have parameter GAMMA_CYCLE_WIDTH, default 16: number of aclk cycles in the RUN window.
REQ-002 SHALL have parameter PULSE_WIDTH, default 8: number of aclk cycles that set_out is asserted.
REQ-003 SHALL have parameter NUM_LINES, default 4: number of race-logic spike lines observed.
REQ-004 SHALL define local TW = $clog2(GAMMA_CYCLE_WIDTH)+1 as the width of each timestamp.
REQ-005 SHALL have port aclk, input, 1 bit: the sole clock, rising-edge.
REQ-006 SHALL have port grst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit: request for one gamma cycle.
REQ-008 SHALL have port continuous, input, 1 bit: when high, restart automatically after REPORT.
REQ-009 SHALL have port lines_in, input, NUM_LINES bits: spike lines from the greater-than/race primitives, synchronous to aclk.
REQ-010 SHALL have port set_out, output, 1 bit: latch-set pulse to the race primitives.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse in REPORT.
REQ-013 SHALL have port times, output, NUM_LINES*TW bits: spike time per line, line i at bits [i*TW +: TW].
REQ-014 SHALL have port fired, output, NUM_LINES bits: per-line flag, high if the line spiked within the window.
REQ-015 SHALL have port winner, output, $clog2(NUM_LINES) bits (minimum 1): index of the earliest line.
REQ-016 SHALL have port winner_valid, output, 1 bit: high if any line fired.

Function
REQ-017 SHALL implement states IDLE, SET, RUN and REPORT.
REQ-018 SHALL go IDLE->SET on the first cycle with start=1; start SHALL be ignored in every other state.
REQ-019 SHALL hold SET for exactly PULSE_WIDTH cycles with set_out=1; set_out SHALL be 0 in all other states.
REQ-020 On SET entry, SHALL clear times to GAMMA_CYCLE_WIDTH and clear fired, winner, winner_valid and the edge-detect history to 0.
REQ-021 SHALL hold RUN for exactly GAMMA_CYCLE_WIDTH cycles, with a cycle counter t running from 0 to GAMMA_CYCLE_WIDTH-1.
REQ-022 In RUN, for each line i with fired[i]=0, lines_in[i]=1 and previous sample 0, SHALL register times[i]=t and fired[i]=1.
REQ-023 The previous sample SHALL be 0 at t=0, so a line already high at t=0 captures time 0.
REQ-024 Each line SHALL capture at most once per gamma cycle; later edges SHALL be ignored.
REQ-025 A line that never fires SHALL keep times[i]=GAMMA_CYCLE_WIDTH (the "infinity" encoding) and fired[i]=0.
REQ-026 SHALL enter REPORT for 1 cycle after RUN, with done=1, winner and winner_valid valid in that same cycle.
REQ-027 SHALL set winner to the minimum times[i] among fired lines; ties SHALL resolve to the lowest index.
REQ-028 If no line fired, SHALL set winner=0 and winner_valid=0.
REQ-029 SHALL leave REPORT for SET if continuous=1, otherwise for IDLE.
REQ-030 SHALL hold times, fired, winner and winner_valid stable from REPORT until the next SET entry.
REQ-031 Total latency from start accepted to done SHALL be PULSE_WIDTH+GAMMA_CYCLE_WIDTH+1 cycles.
REQ-032 The counters SHALL not wrap: the SET count stops at PULSE_WIDTH-1 and t stops at GAMMA_CYCLE_WIDTH-1.
REQ-033 A continuous change mid-cycle SHALL take effect only when sampled in REPORT.

Reset
REQ-034 On grst_n=0, SHALL immediately (asynchronously) enter IDLE with set_out=0, busy=0, done=0, fired=0, winner=0 and winner_valid=0.
REQ-035 Reset SHALL clear all counters and edge-detect history to 0 and set every times entry to GAMMA_CYCLE_WIDTH.
REQ-036 Reset asserted mid-SET or mid-RUN SHALL abort the gamma cycle with no done pulse.
REQ-037 After grst_n deasserts, the block SHALL accept start from the first rising edge.

Verification (GCW=16, PW=8, N=4)
REQ-038 Basic: start pulse; line 2 rises at t=5, line 0 rises at t=9 -> set_out high for 8 cycles, done 25 cycles after start; times = {16,5,16,9} for lines 3..0; fired=0101; winner=2; winner_valid=1.
REQ-039 Tie: lines 1 and 3 rise at t=7 -> winner=1; times[1]=times[3]=7.
REQ-040 No spike: all lines low -> all times=16, fired=0, winner=0, winner_valid=0, done still pulses.
REQ-041 Edge rules: line 0 high from t=0 and line 1 pulsing at t=3 and t=10 -> times[0]=0, times[1]=3.
REQ-042 Continuous: continuous=1 with a single start -> back-to-back cycles, done every 25 cycles; outputs clear on each SET entry; start ignored while busy.
REQ-043 Reset mid-RUN: grst_n low at t=6 -> busy, set_out and fired go 0 immediately and no done pulse; a new start then completes a normal cycle.

Source files
------------

// File: rtl/gamma_sequencer.sv
// gamma_sequencer: sequences one race-logic gamma cycle (SET pulse, RUN window,
// REPORT) and timestamps the first rising edge on each spike line.
module gamma_sequencer #(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned PULSE_WIDTH       = 8,
  parameter int unsigned NUM_LINES         = 4,
  localparam int unsigned TW = $clog2(GAMMA_CYCLE_WIDTH) + 1,
  localparam int unsigned WW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic                      aclk,
  input  logic                      grst_n,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [NUM_LINES-1:0]      lines_in,
  output logic                      set_out,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_LINES*TW-1:0]   times,
  output logic [NUM_LINES-1:0]      fired,
  output logic [WW-1:0]             winner,
  output logic                      winner_valid
);

  localparam int unsigned CW = $clog2(PULSE_WIDTH) + 1;
  localparam logic [TW-1:0] T_INF  = TW'(GAMMA_CYCLE_WIDTH);
  localparam logic [TW-1:0] T_LAST = TW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [CW-1:0] S_LAST = CW'(PULSE_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SET, RUN, REPORT} state_t;

  state_t                    state, state_nxt;
  logic [CW-1:0]             set_cnt;
  logic [TW-1:0]             t_cnt;
  logic [NUM_LINES-1:0]      prev;
  logic [NUM_LINES*TW-1:0]   times_nxt;
  logic [NUM_LINES-1:0]      fired_nxt;
  logic [TW-1:0]             best;
  logic                      found;
  logic [WW-1:0]             winner_c;
  logic                      enter_set;

  // State register plus status outputs registered from the next state
  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      state   <= IDLE;
      set_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      set_out <= (state_nxt == SET);
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == REPORT);
    end
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SET;
      SET:     if (set_cnt == S_LAST) state_nxt = RUN;
      RUN:     if (t_cnt == T_LAST) state_nxt = REPORT;
      REPORT:  state_nxt = continuous ? SET : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_set = (state_nxt == SET) && (state != SET);

  // First-edge capture for this cycle, and the earliest-line pick including it
  always_comb begin
    times_nxt = times;
    fired_nxt = fired;
    best      = T_INF;
    found     = 1'b0;
    winner_c  = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (state == RUN && lines_in[i] && !prev[i] && !fired[i]) begin
        times_nxt[i*TW +: TW] = t_cnt;
        fired_nxt[i]          = 1'b1;
      end
    end
    for (int i = 0; i < NUM_LINES; i++) begin
      if (fired_nxt[i] && (!found || times_nxt[i*TW +: TW] < best)) begin
        found    = 1'b1;
        best     = times_nxt[i*TW +: TW];
        winner_c = WW'(i);
      end
    end
  end

  // Counters, edge history and result registers
  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      set_cnt      <= '0;
      t_cnt        <= '0;
      prev         <= '0;
      times        <= {NUM_LINES{T_INF}};
      fired        <= '0;
      winner       <= '0;
      winner_valid <= 1'b0;
    end else if (enter_set) begin
      set_cnt      <= '0;
      t_cnt        <= '0;
      prev         <= '0;
      times        <= {NUM_LINES{T_INF}};
      fired        <= '0;
      winner       <= '0;
      winner_valid <= 1'b0;
    end else if (state == SET) begin
      if (set_cnt != S_LAST) set_cnt <= set_cnt + CW'(1);
    end else if (state == RUN) begin
      times <= times_nxt;
      fired <= fired_nxt;
      prev  <= lines_in;
      if (t_cnt != T_LAST) begin
        t_cnt <= t_cnt + TW'(1);
      end else begin
        winner       <= winner_c;
        winner_valid <= found;
      end
    end
  end

endmodule

// File: tb/tb_gamma_sequencer.sv
// tb_gamma_sequencer: randomized and directed gamma cycles, scoreboard-checked.
module tb_gamma_sequencer;

  localparam int unsigned GCW = 16;
  localparam int unsigned PW  = 8;
  localparam int unsigned NL  = 4;
  localparam int unsigned TW  = $clog2(GCW) + 1;
  localparam int unsigned WW  = 2;
  localparam logic [NL*TW-1:0] ALL_INF = {NL{TW'(GCW)}};

  typedef struct {
    logic [NL*TW-1:0] times;
    logic [NL-1:0]    fired;
    logic [WW-1:0]    winner;
    logic             wv;
    int unsigned      cyc;
  } exp_t;

  logic aclk = 1'b0;
  logic grst_n = 1'b1;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic [NL-1:0] lines_in = '0;
  logic set_out, busy, done, winner_valid;
  logic [NL*TW-1:0] times;
  logic [NL-1:0] fired;
  logic [WW-1:0] winner;

  exp_t sb[$];
  exp_t last_e;
  exp_t mon_e;
  logic [NL-1:0] wave [GCW];
  int unsigned cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  gamma_sequencer #(
    .GAMMA_CYCLE_WIDTH(GCW), .PULSE_WIDTH(PW), .NUM_LINES(NL)
  ) dut (
    .aclk(aclk), .grst_n(grst_n), .start(start), .continuous(continuous),
    .lines_in(lines_in), .set_out(set_out), .busy(busy), .done(done),
    .times(times), .fired(fired), .winner(winner), .winner_valid(winner_valid)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a line's time is the first RUN sample where it is high; the
  // winner is the smallest such time, lowest index on ties.
  function automatic exp_t model();
    exp_t e;
    int unsigned best;
    e.times = ALL_INF;
    e.fired = '0;
    e.winner = '0;
    e.wv = 1'b0;
    e.cyc = 0;
    for (int i = 0; i < NL; i++)
      for (int t = GCW - 1; t >= 0; t--)
        if (wave[t][i]) begin
          e.times[i*TW +: TW] = TW'(t);
          e.fired[i] = 1'b1;
        end
    best = GCW;
    for (int i = 0; i < NL; i++)
      if (e.fired[i] && int'(e.times[i*TW +: TW]) < best) begin
        best = int'(e.times[i*TW +: TW]);
        e.winner = WW'(i);
        e.wv = 1'b1;
      end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest expected result
  always @(negedge aclk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected none (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("times", 64'(times), 64'(mon_e.times));
        chk("fired", 64'(fired), 64'(mon_e.fired));
        chk("winner", 64'(winner), 64'(mon_e.winner));
        chk("winner_valid", 64'(winner_valid), 64'(mon_e.wv));
      end
    end
  end

  // Called on the negedge of the cycle whose closing edge starts SET;
  // finishes on the REPORT negedge.
  task automatic run_window(input bit cont_end);
    exp_t e;
    e = model();
    e.cyc = cyc + PW + GCW + 1;
    sb.push_back(e);
    last_e = e;
    for (int k = 1; k <= int'(PW); k++) begin
      @(negedge aclk);
      start = 1'($urandom);
      lines_in = NL'($urandom);
      chk("set_out_in_set", 64'(set_out), 64'd1);
      chk("busy_in_set", 64'(busy), 64'd1);
      if (k == 1) begin
        chk("times_clear", 64'(times), 64'(ALL_INF));
        chk("fired_clear", 64'(fired), 64'd0);
        chk("winner_clear", 64'(winner), 64'd0);
        chk("wv_clear", 64'(winner_valid), 64'd0);
      end
    end
    for (int t = 0; t < int'(GCW); t++) begin
      @(negedge aclk);
      start = 1'($urandom);
      lines_in = wave[t];
      if (t == int'(GCW / 2)) continuous = cont_end;
      chk("set_out_in_run", 64'(set_out), 64'd0);
      chk("busy_in_run", 64'(busy), 64'd1);
    end
    @(negedge aclk);
    start = 1'b0;
    lines_in = NL'($urandom);
    chk("set_out_in_report", 64'(set_out), 64'd0);
  endtask

  // After a non-continuous window: back in IDLE with results held
  task automatic idle_check();
    @(negedge aclk);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("done_idle", 64'(done), 64'd0);
    chk("set_out_idle", 64'(set_out), 64'd0);
    chk("times_hold", 64'(times), 64'(last_e.times));
    chk("fired_hold", 64'(fired), 64'(last_e.fired));
    chk("winner_hold", 64'(winner), 64'(last_e.winner));
    chk("wv_hold", 64'(winner_valid), 64'(last_e.wv));
  endtask

  task automatic one_shot();
    @(negedge aclk);
    start = 1'b1;
    continuous = 1'b0;
    run_window(1'b0);
    idle_check();
  endtask

  task automatic wave_clear();
    for (int t = 0; t < int'(GCW); t++) wave[t] = '0;
  endtask

  task automatic wave_step(input int line, input int t0);
    for (int t = 0; t < int'(GCW); t++) if (t >= t0) wave[t][line] = 1'b1;
  endtask

  task automatic wave_random();
    int mode;
    wave_clear();
    for (int i = 0; i < int'(NL); i++) begin
      mode = int'($urandom_range(0, 3));
      if (mode == 1) wave_step(i, int'($urandom_range(0, GCW - 1)));
      else if (mode == 2)
        for (int t = 0; t < int'(GCW); t++) wave[t][i] = ($urandom_range(0, 3) == 0);
      else if (mode == 3) wave_step(i, int'($urandom_range(4, 7)));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 grst_n = 1'b0;
    @(negedge aclk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_set_out", 64'(set_out), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_times", 64'(times), 64'(ALL_INF));
    chk("rst_fired", 64'(fired), 64'd0);
    chk("rst_winner", 64'(winner), 64'd0);
    chk("rst_wv", 64'(winner_valid), 64'd0);
    @(negedge aclk);
    grst_n = 1'b1;

    // Basic: line 2 at t=5, line 0 at t=9
    wave_clear(); wave_step(2, 5); wave_step(0, 9);
    one_shot();
    // Tie: lines 1 and 3 at t=7
    wave_clear(); wave_step(1, 7); wave_step(3, 7);
    one_shot();
    // No spikes
    wave_clear();
    one_shot();
    // Line 0 high from t=0, line 1 pulses at t=3 and t=10
    wave_clear(); wave_step(0, 0); wave[3][1] = 1'b1; wave[10][1] = 1'b1;
    one_shot();

    // Continuous: one start, three back-to-back cycles, drop continuous in the last
    wave_random();
    @(negedge aclk);
    start = 1'b1;
    continuous = 1'b1;
    run_window(1'b1);
    wave_random();
    run_window(1'b1);
    wave_clear(); wave_step(3, 2); wave_step(1, 12);
    run_window(1'b0);
    idle_check();

    // Reset at t=6 of RUN with line 3 already captured
    @(negedge aclk);
    start = 1'b1;
    for (int k = 1; k <= int'(PW); k++) begin
      @(negedge aclk);
      start = 1'b0;
      lines_in = '0;
    end
    for (int t = 0; t < 6; t++) begin
      @(negedge aclk);
      lines_in = (t >= 2) ? NL'(4'b1000) : '0;
    end
    @(negedge aclk);
    chk("fired_before_rst", 64'(fired), 64'b1000);
    chk("busy_before_rst", 64'(busy), 64'd1);
    grst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_set_out", 64'(set_out), 64'd0);
    chk("abort_fired", 64'(fired), 64'd0);
    chk("abort_times", 64'(times), 64'(ALL_INF));
    chk("abort_wv", 64'(winner_valid), 64'd0);
    repeat (3) @(negedge aclk);
    lines_in = '0;
    grst_n = 1'b1;
    start = 1'b1;
    wave_clear(); wave_step(2, 5); wave_step(0, 9);
    run_window(1'b0);
    idle_check();

    // Randomized one-shot cycles
    for (int n = 0; n < 8; n++) begin
      wave_random();
      one_shot();
    end

    repeat (3) @(negedge aclk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
